// File: rtl/breadboard.sv
// breadboard -- four-way intersection traffic-light controller.
//
// Eight inbound lanes are served two at a time by approach: WEST (W1,W2),
// SOUTH (S1,S2), EAST (E1,E2) and NORTH (N1,N2). A countdown timer holds
// each phase; when it reaches zero the next phase is granted green and the
// timer reloads from a mode-dependent value. Modes:
//   0 DAY    reload scales with the car counts of the phase being granted
//   1 NIGHT  fixed reload, approaches with no cars are skipped
//   2 EMG    emergency pre-emption, greens taken directly from emgLane
//   3 PED    all-red with every walk light on
//
// Ports
//   clk                 rising-edge clock
//   rst                 asynchronous reset, active low
//   hoursIn[4:0]        hour of day (0..23, 24..31 treated as night)
//   pedSignal           pedestrian request, latched until serviced
//   emgSignal           emergency pre-emption active (level)
//   emgLane[7:0]        emergency greens, order {W1,W2,S1,S2,E1,E2,N1,N2}
//   lanes[63:0]         car counts, 8 bits each, order {W1,W2,S1,S2,E1,E2,N1,N2}
//   trafficLightOutput  1=green: [0]S1 [1]S2 [2]E1 [3]E2 [4]N1 [5]N2 [6]W1 [7]W2
module breadboard #(
  parameter int DAY_BASE   = 10,
  parameter int NIGHT_TIME = 5,
  parameter int EMG_TIME   = 3,
  parameter int PED_TIME   = 6,
  parameter int DAY_START  = 6,
  parameter int DAY_END    = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  hoursIn,
  input  logic        pedSignal,
  input  logic        emgSignal,
  input  logic [7:0]  emgLane,
  input  logic [63:0] lanes,
  output logic [7:0]  trafficLightOutput
);

  localparam logic [1:0] PH_WEST  = 2'd0;
  localparam logic [1:0] PH_SOUTH = 2'd1;
  localparam logic [1:0] PH_EAST  = 2'd2;
  localparam logic [1:0] PH_NORTH = 2'd3;

  localparam logic [1:0] MODE_DAY   = 2'd0;
  localparam logic [1:0] MODE_NIGHT = 2'd1;
  localparam logic [1:0] MODE_EMG   = 2'd2;
  localparam logic [1:0] MODE_PED   = 2'd3;

  localparam logic [4:0] DAY_START_H = DAY_START[4:0];
  localparam logic [4:0] DAY_END_H   = DAY_END[4:0];
  localparam logic [7:0] DAY_BASE_W  = DAY_BASE[7:0];
  localparam logic [6:0] NIGHT_W     = NIGHT_TIME[6:0];
  localparam logic [6:0] EMG_W       = EMG_TIME[6:0];
  localparam logic [6:0] PED_W       = PED_TIME[6:0];

  // Registered state
  logic [7:0] light_q, light_d;
  logic [7:0] walk_q, walk_d;
  logic [6:0] count_q, count_d;
  logic [1:0] phase_q, phase_d;   // next approach to be granted green
  logic       ped_q, ped_d;       // pending pedestrian request
  logic       emg_q, emg_d;       // emergency was active on the previous edge

  // Named internal nets
  logic [7:0] walkingLightOutput;
  logic       dayNightSignal;
  logic [1:0] trafficMode;
  logic [6:0] currentCount;
  logic [6:0] dayLoadTime, nightLoadTime, emgLoadTime, pedLoadTime, loadIn;

  // Day-load arithmetic and night skip search
  logic [15:0] next_cnts;
  logic [8:0]  lane_sum;
  logic [7:0]  day_raw;
  logic        night_found;
  logic [1:0]  night_phase;

  // Car counts of one approach, {laneA, laneB}.
  function automatic logic [15:0] phase_counts(input logic [1:0] ph, input logic [63:0] ln);
    case (ph)
      PH_WEST:  return ln[63:48];
      PH_SOUTH: return ln[47:32];
      PH_EAST:  return ln[31:16];
      default:  return ln[15:0];
    endcase
  endfunction

  function automatic logic [7:0] phase_green(input logic [1:0] ph);
    case (ph)
      PH_WEST:  return 8'hC0;
      PH_SOUTH: return 8'h03;
      PH_EAST:  return 8'h0C;
      default:  return 8'h30;
    endcase
  endfunction

  // emgLane is ordered W1..N2 from the top bit; the output vector puts the
  // south pair in the low bits and west on top.
  function automatic logic [7:0] emg_remap(input logic [7:0] e);
    return {e[6], e[7], e[0], e[1], e[2], e[3], e[4], e[5]};
  endfunction

  assign trafficLightOutput = light_q;
  assign walkingLightOutput = walk_q;
  assign currentCount       = count_q;

  assign dayNightSignal = (hoursIn >= DAY_START_H) && (hoursIn < DAY_END_H);

  // Day reload: base plus a quarter of the granted approach's cars, capped
  // at the 7-bit counter range. The 9-bit sum cannot overflow.
  assign next_cnts     = phase_counts(phase_q, lanes);
  assign lane_sum      = {1'b0, next_cnts[15:8]} + {1'b0, next_cnts[7:0]};
  assign day_raw       = DAY_BASE_W + {1'b0, lane_sum[8:2]};
  assign dayLoadTime   = (day_raw > 8'd127) ? 7'd127 : day_raw[6:0];
  assign nightLoadTime = NIGHT_W;
  assign emgLoadTime   = EMG_W;
  assign pedLoadTime   = PED_W;

  always_comb begin
    if (emgSignal)                     trafficMode = MODE_EMG;
    else if (ped_q && count_q == 7'd0) trafficMode = MODE_PED;
    else if (dayNightSignal)           trafficMode = MODE_DAY;
    else                               trafficMode = MODE_NIGHT;
  end

  always_comb begin
    case (trafficMode)
      MODE_DAY:   loadIn = dayLoadTime;
      MODE_NIGHT: loadIn = nightLoadTime;
      MODE_EMG:   loadIn = emgLoadTime;
      default:    loadIn = pedLoadTime;
    endcase
  end

  // Night: first approach with any cars, starting at the pending phase.
  // Iterating downward lets the nearest candidate win.
  always_comb begin
    night_found = 1'b0;
    night_phase = phase_q;
    for (int k = 3; k >= 0; k--) begin
      logic [1:0] cand;
      cand = phase_q + 2'(k);
      if (phase_counts(cand, lanes) != 16'd0) begin
        night_found = 1'b1;
        night_phase = cand;
      end
    end
  end

  always_comb begin
    light_d = light_q;
    walk_d  = walk_q;
    count_d = count_q;
    phase_d = phase_q;
    ped_d   = ped_q | pedSignal;
    emg_d   = emgSignal;
    if (emgSignal) begin
      // Pre-empt regardless of the timer; the pending phase is kept so
      // rotation continues after the interrupted approach.
      light_d = emg_remap(emgLane);
      walk_d  = 8'h00;
      count_d = loadIn;
    end else if (emg_q) begin
      // Release edge: one all-red cycle with the timer expired.
      light_d = 8'h00;
      walk_d  = 8'h00;
      count_d = 7'd0;
    end else if (count_q != 7'd0) begin
      count_d = count_q - 7'd1;
    end else begin
      count_d = loadIn;
      walk_d  = 8'h00;
      case (trafficMode)
        MODE_PED: begin
          light_d = 8'h00;
          walk_d  = 8'hFF;
          ped_d   = 1'b0;
        end
        MODE_DAY: begin
          light_d = phase_green(phase_q);
          phase_d = phase_q + 2'd1;
        end
        default: begin
          if (night_found) begin
            light_d = phase_green(night_phase);
            phase_d = night_phase + 2'd1;
          end else begin
            light_d = 8'h00;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      light_q <= 8'h00;
      walk_q  <= 8'h00;
      count_q <= 7'd0;
      phase_q <= PH_WEST;
      ped_q   <= 1'b0;
      emg_q   <= 1'b0;
    end else begin
      light_q <= light_d;
      walk_q  <= walk_d;
      count_q <= count_d;
      phase_q <= phase_d;
      ped_q   <= ped_d;
      emg_q   <= emg_d;
    end
  end

endmodule

// File: tb/tb_breadboard.sv
// Testbench for breadboard: directed scenarios followed by randomized
// traffic, emergency and pedestrian activity, scored against a behavioural
// model of the intersection rules.
module tb_breadboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  hoursIn;
  logic        pedSignal;
  logic        emgSignal;
  logic [7:0]  emgLane;
  logic [63:0] lanes;
  logic [7:0]  trafficLightOutput;

  always #5 clk = ~clk;

  breadboard dut (
    .clk                (clk),
    .rst                (rst),
    .hoursIn            (hoursIn),
    .pedSignal          (pedSignal),
    .emgSignal          (emgSignal),
    .emgLane            (emgLane),
    .lanes              (lanes),
    .trafficLightOutput (trafficLightOutput)
  );

  typedef struct packed {
    logic [7:0] light;
    logic [7:0] walk;
    logic [6:0] count;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: approaches 0=W 1=S 2=E 3=N, lanes ordered W1..N2.
  int         m_next;
  int         m_count;
  logic [7:0] m_light;
  logic [7:0] m_walk;
  bit         m_ped;
  bit         m_emg_prev;
  logic [7:0] green_of [4] = '{8'hC0, 8'h03, 8'h0C, 8'h30};
  int         out_bit_of [8] = '{6, 7, 0, 1, 2, 3, 4, 5};  // W1,W2,S1,S2,E1,E2,N1,N2

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lane_count(input int ph, input int k);
    return int'(lanes[63 - 8 * (2 * ph + k) -: 8]);
  endfunction

  function automatic bit is_day();
    return (hoursIn >= 5'd6) && (hoursIn < 5'd20);
  endfunction

  function automatic int model_mode();
    if (emgSignal) return 2;
    if (m_ped && m_count == 0) return 3;
    return is_day() ? 0 : 1;
  endfunction

  function automatic int model_load(input int mode);
    int v;
    case (mode)
      0: begin
        v = 10 + (lane_count(m_next, 0) + lane_count(m_next, 1)) / 4;
        return (v > 127) ? 127 : v;
      end
      1: return 5;
      2: return 3;
      default: return 6;
    endcase
  endfunction

  task automatic model_reset();
    m_next = 0; m_count = 0; m_light = 8'h00; m_walk = 8'h00;
    m_ped = 1'b0; m_emg_prev = 1'b0;
  endtask

  task automatic model_step();
    int mode;
    int ld;
    int found;
    if (!rst) begin
      model_reset();
      return;
    end
    mode = model_mode();
    ld   = model_load(mode);
    if (emgSignal) begin
      m_light = 8'h00;
      for (int i = 0; i < 8; i++)
        if (emgLane[7 - i]) m_light[out_bit_of[i]] = 1'b1;
      m_walk = 8'h00; m_count = ld; m_emg_prev = 1'b1;
      m_ped = m_ped | pedSignal;
    end else if (m_emg_prev) begin
      m_light = 8'h00; m_walk = 8'h00; m_count = 0; m_emg_prev = 1'b0;
      m_ped = m_ped | pedSignal;
    end else if (m_count > 0) begin
      m_count = m_count - 1;
      m_ped = m_ped | pedSignal;
    end else if (mode == 3) begin
      m_light = 8'h00; m_walk = 8'hFF; m_count = ld; m_ped = 1'b0;
    end else if (mode == 0) begin
      m_light = green_of[m_next]; m_walk = 8'h00; m_count = ld;
      m_next = (m_next + 1) % 4;
      m_ped = m_ped | pedSignal;
    end else begin
      found = -1;
      for (int k = 0; k < 4; k++) begin
        int c;
        c = (m_next + k) % 4;
        if (found < 0 && (lane_count(c, 0) != 0 || lane_count(c, 1) != 0)) found = c;
      end
      if (found >= 0) begin
        m_light = green_of[found];
        m_next  = (found + 1) % 4;
      end else begin
        m_light = 8'h00;
      end
      m_walk = 8'h00; m_count = ld;
      m_ped = m_ped | pedSignal;
    end
  endtask

  // Drive one clock period: inputs change on the falling edge, the mode
  // nets are checked against the model, and the expected post-edge state
  // is queued for the monitor.
  task automatic cycle(input bit r, input logic [4:0] h, input bit p, input bit em,
                       input logic [7:0] el, input logic [63:0] ln);
    exp_t e;
    int   mode;
    @(negedge clk);
    rst = r; hoursIn = h; pedSignal = p; emgSignal = em; emgLane = el; lanes = ln;
    if (!r) model_reset();
    #1;
    mode = model_mode();
    chk("traffic_mode", {30'd0, dut.trafficMode}, 32'(mode));
    chk("day_night", {31'd0, dut.dayNightSignal}, is_day() ? 32'd1 : 32'd0);
    chk("load_in", {25'd0, dut.loadIn}, 32'(model_load(mode)));
    model_step();
    e.light = m_light;
    e.walk  = m_walk;
    e.count = 7'(m_count);
    sb.push_back(e);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_state(input string name, input logic [7:0] light, input logic [7:0] walk,
                           input logic [6:0] count);
    chk({name, "_light"}, {24'd0, trafficLightOutput}, {24'd0, light});
    chk({name, "_walk"},  {24'd0, dut.walkingLightOutput}, {24'd0, walk});
    chk({name, "_count"}, {25'd0, dut.currentCount}, {25'd0, count});
  endtask

  function automatic logic [63:0] rand_lanes();
    logic [63:0] v;
    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(0, 3))
        0:       v[8 * i +: 8] = 8'h00;
        1:       v[8 * i +: 8] = 8'($urandom_range(200, 255));
        default: v[8 * i +: 8] = 8'($urandom_range(1, 40));
      endcase
    end
    return v;
  endfunction

  // Monitor: every state update is compared with the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_light", {24'd0, trafficLightOutput}, {24'd0, e.light});
        chk("sb_walk",  {24'd0, dut.walkingLightOutput}, {24'd0, e.walk});
        chk("sb_count", {25'd0, dut.currentCount}, {25'd0, e.count});
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] l1, l4, ln;
    logic [4:0]  h;
    logic [7:0]  el;
    int          emg_left;

    l1 = {8'h30, 8'h0E, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0F};
    l4 = {8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00};

    // Reset values
    rst = 1'b0; hoursIn = 5'd12; pedSignal = 1'b0; emgSignal = 1'b0;
    emgLane = 8'h00; lanes = l1;
    model_reset();
    #12;
    chk_state("reset", 8'h00, 8'h00, 7'd0);
    chk("reset_mode", {30'd0, dut.trafficMode}, 32'd0);

    // Day rotation: W 26 cycles, S 11, E 11, N 14, back to W
    cycle(1, 5'd12, 0, 0, 8'h00, l1);
    after_edge(); chk_state("day_west", 8'hC0, 8'h00, 7'd25);
    repeat (25) cycle(1, 5'd12, 0, 0, 8'h00, l1);
    cycle(1, 5'd12, 0, 0, 8'h00, l1);
    after_edge(); chk_state("day_south", 8'h03, 8'h00, 7'd10);
    repeat (10) cycle(1, 5'd12, 0, 0, 8'h00, l1);
    cycle(1, 5'd12, 0, 0, 8'h00, l1);
    after_edge(); chk_state("day_east", 8'h0C, 8'h00, 7'd10);
    repeat (10) cycle(1, 5'd12, 0, 0, 8'h00, l1);
    cycle(1, 5'd12, 0, 0, 8'h00, l1);
    after_edge(); chk_state("day_north", 8'h30, 8'h00, 7'd13);
    repeat (13) cycle(1, 5'd12, 0, 0, 8'h00, l1);
    cycle(1, 5'd12, 0, 0, 8'h00, l1);
    after_edge(); chk_state("day_west2", 8'hC0, 8'h00, 7'd25);

    // Emergency mid-WEST, then release into SOUTH
    repeat (3) cycle(1, 5'd12, 0, 0, 8'h00, l1);
    cycle(1, 5'd12, 0, 1, 8'h08, l1);
    after_edge(); chk_state("emg_e1", 8'h04, 8'h00, 7'd3);
    repeat (2) cycle(1, 5'd12, 0, 1, 8'h08, l1);
    after_edge(); chk_state("emg_hold", 8'h04, 8'h00, 7'd3);
    cycle(1, 5'd12, 0, 0, 8'h00, l1);
    cycle(1, 5'd12, 0, 0, 8'h00, l1);
    after_edge(); chk_state("emg_release_south", 8'h03, 8'h00, 7'd10);

    // Night: only SOUTH and EAST have cars
    repeat (2) cycle(0, 5'd22, 0, 0, 8'h00, l4);
    cycle(1, 5'd22, 0, 0, 8'h00, l4);
    after_edge(); chk_state("night_south", 8'h03, 8'h00, 7'd5);
    repeat (5) cycle(1, 5'd22, 0, 0, 8'h00, l4);
    cycle(1, 5'd22, 0, 0, 8'h00, l4);
    after_edge(); chk_state("night_east", 8'h0C, 8'h00, 7'd5);
    repeat (5) cycle(1, 5'd22, 0, 0, 8'h00, l4);
    cycle(1, 5'd22, 0, 0, 8'h00, l4);
    after_edge(); chk_state("night_skip_to_south", 8'h03, 8'h00, 7'd5);

    // Pedestrian pulse at night
    cycle(1, 5'd22, 1, 0, 8'h00, l4);
    repeat (4) cycle(1, 5'd22, 0, 0, 8'h00, l4);
    cycle(1, 5'd22, 0, 0, 8'h00, l4);
    after_edge(); chk_state("ped_walk", 8'h00, 8'hFF, 7'd6);
    repeat (6) cycle(1, 5'd22, 0, 0, 8'h00, l4);
    cycle(1, 5'd22, 0, 0, 8'h00, l4);
    after_edge(); chk_state("ped_resume_east", 8'h0C, 8'h00, 7'd5);

    // Night with no cars anywhere
    repeat (12) cycle(1, 5'd2, 0, 0, 8'h00, 64'd0);

    // Asynchronous reset during emergency with a pedestrian request pending
    cycle(1, 5'd12, 1, 1, 8'h81, l1);
    after_edge(); chk_state("emg_w1_n2", 8'h60, 8'h00, 7'd3);
    rst = 1'b0;
    #1;
    chk_state("async_reset", 8'h00, 8'h00, 7'd0);
    model_reset();
    repeat (2) cycle(0, 5'd12, 0, 1, 8'h81, l1);
    cycle(1, 5'd12, 0, 0, 8'h00, l1);
    after_edge(); chk_state("post_reset_no_ped", 8'hC0, 8'h00, 7'd25);

    // Randomized traffic
    h = 5'd12; ln = rand_lanes(); el = 8'h00; emg_left = 0;
    repeat (2500) begin
      if (emg_left > 0) emg_left--;
      else if ($urandom_range(0, 39) == 0) begin
        emg_left = $urandom_range(1, 6);
        el = 8'($urandom);
      end
      if ($urandom_range(0, 29) == 0) h = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 19) == 0) ln = rand_lanes();
      cycle($urandom_range(0, 399) != 0, h, $urandom_range(0, 19) == 0,
            emg_left > 0, el, ln);
    end

    @(posedge clk);
    #3;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
